// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, command/response bytes and
// a helper that builds the host-to-device frame.
package ps2_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StStart,
        StSend,
        StAck,
        StWaitIdle
    } ps2_tx_state_e;

    localparam logic [7:0] CMD_RESET  = 8'hFF;
    localparam logic [7:0] CMD_ENABLE = 8'hF4;
    localparam logic [7:0] RSP_ACK    = 8'hFA;

    // D0..D7, parity, stop
    localparam int unsigned FRAME_BITS = 10;

    // Frame as shifted out LSB first: {stop, odd parity, data}.
    function automatic logic [FRAME_BITS-1:0] ps2_frame(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for one PS/2 pad plus a falling-edge detector.
// Resets to 1 (idle line level) so leaving reset never produces a false edge.
module ps2_line_sync (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_pad,
    output logic o_level,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_pad;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_fall  = r_prev & ~r_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, byte + odd parity shifted out on
// device clocks, line-level acknowledge check and inter-edge timeout.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 2500,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_start,
    output logic       o_tx_busy,
    output logic       o_tx_done,
    output logic       o_tx_error,
    input  logic       i_ps2_clk_in,
    input  logic       i_ps2_data_in,
    output logic       o_ps2_clk_out,
    output logic       o_ps2_data_out,
    output logic       o_ps2_clk_oe,
    output logic       o_ps2_data_oe
);

    localparam int unsigned CntMax =
        (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CntW = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] InhibitLast = CntW'(INHIBIT_CYCLES - 1);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]      StopIdx     = 4'(FRAME_BITS - 1);

    logic w_clk_level;
    logic w_clk_fall;
    logic w_data_level;
    logic w_data_fall_unused;

    ps2_line_sync u_clk_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_pad   (i_ps2_clk_in),
        .o_level (w_clk_level),
        .o_fall  (w_clk_fall)
    );

    ps2_line_sync u_data_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_pad   (i_ps2_data_in),
        .o_level (w_data_level),
        .o_fall  (w_data_fall_unused)
    );

    ps2_tx_state_e          r_state;
    logic [FRAME_BITS-1:0]  r_shift;
    logic [CntW-1:0]        r_cnt;
    logic [3:0]             r_bit_idx;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_error;
    logic                   r_clk_oe;
    logic                   r_data_oe;
    logic                   r_data_out;

    // r_cnt is the inhibit timer in StInhibit and the inter-edge timeout in StSend/StAck.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= StIdle;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_clk_oe   <= 1'b0;
            r_data_oe  <= 1'b0;
            r_data_out <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    if (i_tx_start) begin
                        r_shift  <= ps2_frame(i_tx_data);
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_clk_oe <= 1'b1;
                        r_state  <= StInhibit;
                    end
                end
                StInhibit: begin
                    if (r_cnt == InhibitLast) begin
                        r_data_oe  <= 1'b1;
                        r_data_out <= 1'b0;
                        r_state    <= StStart;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StStart: begin
                    r_clk_oe  <= 1'b0;
                    r_bit_idx <= '0;
                    r_cnt     <= '0;
                    r_state   <= StSend;
                end
                StSend: begin
                    if (w_clk_fall) begin
                        r_cnt <= '0;
                        if (r_bit_idx == StopIdx) begin
                            // Stop bit is a release; the pull-up supplies the 1.
                            r_data_oe <= 1'b0;
                            r_state   <= StAck;
                        end else begin
                            r_data_out <= r_shift[0];
                            r_shift    <= r_shift >> 1;
                            r_bit_idx  <= r_bit_idx + 1'b1;
                        end
                    end else if (r_cnt == TimeoutLast) begin
                        r_error   <= 1'b1;
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b0;
                        r_state   <= StWaitIdle;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StAck: begin
                    if (w_clk_fall) begin
                        r_cnt <= '0;
                        if (!w_data_level) begin
                            r_done <= 1'b1;
                        end else begin
                            r_error <= 1'b1;
                        end
                        r_state <= StWaitIdle;
                    end else if (r_cnt == TimeoutLast) begin
                        r_error   <= 1'b1;
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b0;
                        r_state   <= StWaitIdle;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StWaitIdle: begin
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    if (w_clk_level && w_data_level) begin
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end
                end
                default: begin
                    r_state   <= StIdle;
                    r_busy    <= 1'b0;
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                end
            endcase
        end
    end

    // The host only ever pulls the clock low; the OE alone decides whether it does.
    assign o_ps2_clk_out  = 1'b0;
    assign o_ps2_clk_oe   = r_clk_oe;
    assign o_ps2_data_oe  = r_data_oe;
    assign o_ps2_data_out = r_data_out;
    assign o_tx_busy      = r_busy;
    assign o_tx_done      = r_done;
    assign o_tx_error     = r_error;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple PS/2 device model on wired-AND pads.
module tb_ps2_host_tx;

    localparam int unsigned Inhibit = 8;
    localparam int unsigned Timeout = 64;
    localparam int          Half    = 20;

    logic       clk;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy, tx_done, tx_error;
    logic       clk_out, data_out, clk_oe, data_oe;
    logic       dev_clk, dev_data;
    logic       pad_clk, pad_data;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int g_done = 0, g_err = 0, g_both = 0;
    int g_done_cyc = 0, g_err_cyc = 0;

    assign pad_clk  = (clk_oe  ? clk_out  : 1'b1) & dev_clk;
    assign pad_data = (data_oe ? data_out : 1'b1) & dev_data;

    ps2_host_tx #(
        .INHIBIT_CYCLES (Inhibit),
        .TIMEOUT_CYCLES (Timeout)
    ) dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_tx_data      (tx_data),
        .i_tx_start     (tx_start),
        .o_tx_busy      (tx_busy),
        .o_tx_done      (tx_done),
        .o_tx_error     (tx_error),
        .i_ps2_clk_in   (pad_clk),
        .i_ps2_data_in  (pad_data),
        .o_ps2_clk_out  (clk_out),
        .o_ps2_data_out (data_out),
        .o_ps2_clk_oe   (clk_oe),
        .o_ps2_data_oe  (data_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (tx_done) begin
            g_done++;
            g_done_cyc = cyc;
        end
        if (tx_error) begin
            g_err++;
            g_err_cyc = cyc;
        end
        if (tx_done && tx_error) g_both++;
    endtask

    task automatic clear_counts();
        g_done = 0;
        g_err  = 0;
        g_both = 0;
    endtask

    // Issues a start and checks the request-to-send sequence; returns in the first SEND cycle.
    task automatic send_cmd(input string tag, input logic [7:0] b);
        int n;
        int guard;
        tx_data  = b;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        check({tag, "_busy_rise"}, 32'(tx_busy), 32'd1);
        check({tag, "_clk_oe_rise"}, 32'(clk_oe), 32'd1);
        check({tag, "_clk_out_low"}, 32'(clk_out), 32'd0);
        n = 0;
        guard = 0;
        while (!data_oe && guard < 100) begin
            if (clk_oe) n++;
            guard++;
            tick();
        end
        check({tag, "_inhibit_len"}, 32'(n), 32'(Inhibit));
        check({tag, "_start_bit"}, {30'd0, data_oe, data_out}, 32'b10);
        check({tag, "_start_clk_held"}, 32'(clk_oe), 32'd1);
        tick();
        check({tag, "_clk_release"}, {30'd0, clk_oe, data_oe}, 32'b01);
    endtask

    // Device model: 11 clocks, samples the line just before each rising edge.
    task automatic dev_frame(input bit ack_low, input int inject_at, input int abort_after,
                             output logic [9:0] bits, output int fall11_cyc);
        bits = '0;
        fall11_cyc = 0;
        for (int i = 0; i < 11; i++) begin
            for (int j = 0; j < Half; j++) tick();
            dev_clk = 1'b0;
            if (i == 10) fall11_cyc = cyc;
            for (int j = 0; j < Half; j++) begin
                tx_start = (i == inject_at) && (j == 5);
                if (tx_start) tx_data = 8'h00;
                tick();
            end
            tx_start = 1'b0;
            if (i < 10) bits[i] = pad_data;
            dev_clk = 1'b1;
            if (i == abort_after) return;
            if (i == 9) dev_data = ack_low ? 1'b0 : 1'b1;
            if (i == 10) dev_data = 1'b1;
        end
    endtask

    task automatic wait_idle(input string tag);
        int guard;
        guard = 0;
        while (tx_busy && guard < 200) begin
            tick();
            guard++;
        end
        check({tag, "_idle"}, 32'(tx_busy), 32'd0);
        check({tag, "_idle_oe"}, {30'd0, clk_oe, data_oe}, 32'd0);
    endtask

    task automatic run_full(input string tag, input logic [7:0] b, input logic [9:0] exp_bits,
                            input bit ack_low, input int inject_at);
        logic [9:0] bits;
        int f11;
        clear_counts();
        send_cmd(tag, b);
        dev_frame(ack_low, inject_at, -1, bits, f11);
        check({tag, "_bits"}, 32'(bits), 32'(exp_bits));
        check({tag, "_done_cnt"}, 32'(g_done), ack_low ? 32'd1 : 32'd0);
        check({tag, "_err_cnt"}, 32'(g_err), ack_low ? 32'd0 : 32'd1);
        check({tag, "_both"}, 32'(g_both), 32'd0);
        check({tag, "_result_lat"}, 32'((ack_low ? g_done_cyc : g_err_cyc) - f11), 32'd3);
        wait_idle(tag);
    endtask

    initial begin
        logic [9:0] bits;
        int f11;
        int k;
        rst      = 1'b1;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        repeat (3) tick();
        check("rst_outputs", {25'd0, clk_out, data_out, clk_oe, data_oe, tx_busy, tx_done,
                              tx_error}, 32'd0);
        rst = 1'b0;
        repeat (2) tick();
        check("post_rst_idle", {29'd0, tx_busy, clk_oe, data_oe}, 32'd0);

        // 0xF4: D=0,0,1,0,1,1,1,1  P=0  stop=1
        run_full("f4", 8'hF4, 10'b1_0_1111_0100, 1'b1, -1);
        // 0xFF: all ones, P=1
        run_full("ff", 8'hFF, 10'b1_1_1111_1111, 1'b1, -1);
        // Device never pulls data low for the ack
        run_full("nack", 8'hFF, 10'b1_1_1111_1111, 1'b0, -1);
        // Second start with 0x00 during SEND must not disturb the 0xF4 frame
        run_full("busy_ign", 8'hF4, 10'b1_0_1111_0100, 1'b1, 3);

        // Timeout: no device clocks after the start bit
        clear_counts();
        send_cmd("tmo", 8'hF4);
        k = 0;
        while (!tx_error && k < 200) begin
            tick();
            k++;
        end
        check("tmo_latency", 32'(k), 32'(Timeout));
        check("tmo_oe", {30'd0, clk_oe, data_oe}, 32'd0);
        check("tmo_done", 32'(g_done), 32'd0);
        tick();
        check("tmo_err_pulse", 32'(tx_error), 32'd0);
        wait_idle("tmo");

        // Reset after four data bits
        clear_counts();
        send_cmd("rstmid", 8'hF4);
        dev_frame(1'b1, -1, 3, bits, f11);
        check("rstmid_bits", 32'(bits[3:0]), 32'b0100);
        check("rstmid_pre_oe", 32'(data_oe), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rstmid_async", {29'd0, tx_busy, clk_oe, data_oe}, 32'd0);
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();
        check("rstmid_quiet", 32'(g_done + g_err), 32'd0);
        run_full("after_rst", 8'hF4, 10'b1_0_1111_0100, 1'b1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device transmitter for a PS/2 port. It performs the request-to-send sequence (clock inhibit, start bit), shifts out one command byte with odd parity on device-generated clocks, and checks the device's line-level acknowledge. It sits beside `ps2_support` on the mouse port, initialising the mouse with commands such as 0xFF (reset) and 0xF4 (enable reporting). It drives the open-drain pad controls that the top level muxes onto `ps2_mouse_clk_out` and `ps2_mouse_data_out`.

## Interface
- `INHIBIT_CYCLES`, default 2500: clock-low hold before the start bit (≥100 µs at `cpu_clk`).
- `TIMEOUT_CYCLES`, default 50000: maximum clk cycles between device falling edges before abort.
- `clk`  in  1  `cpu_clk` domain; the only clock.
- `reset`  in  1  asynchronous, active-high.
- `tx_data`  in  8  command byte; sampled when a start is accepted.
- `tx_start`  in  1  one-cycle request; ignored while `tx_busy`=1.
- `tx_busy`  out  1  high from acceptance until return to IDLE.
- `tx_done`  out  1  one-cycle pulse: device acknowledged.
- `tx_error`  out  1  one-cycle pulse: no ack (data=1) or timeout.
- `ps2_clk_in`, `ps2_data_in`  in  1  raw pad levels (asynchronous).
- `ps2_clk_out`, `ps2_data_out`  out  1  level driven when the matching OE is 1.
- `ps2_clk_oe`, `ps2_data_oe`  out  1  1 = drive the line, 0 = release it (pulled high).

## Operation
- Both pad inputs pass through a 2-flop synchroniser plus a previous-value flop. A falling edge (`fall`) means prev=1 and cur=0.
- Parity bit P = ~^tx_data (odd parity). The shift register is loaded with {stop=1, P, tx_data[7:0]} and shifts LSB first.
- State machine, all outputs registered:
  - **IDLE**: both OEs=0, busy=0. On `tx_start`: latch the frame, clear the counter, go to INHIBIT.
  - **INHIBIT**: clk_oe=1, clk_out=0. When the counter reaches INHIBIT_CYCLES-1, go to START.
  - **START**: clk still driven low; data_oe=1, data_out=0 (start bit). Hold for one cycle, then go to SEND with clk_oe=0 and the bit index cleared.
  - **SEND**: on each `fall`, drive the next frame bit. Bits D0..D7 and P drive data_out=bit. The stop bit is sent by setting data_oe=0 (release). After the 10th `fall` (stop placed), go to ACK.
  - **ACK**: on the next `fall`, sample synchronised data. If 0, pulse tx_done; if 1, pulse tx_error. Then go to WAIT_IDLE.
  - **WAIT_IDLE**: both lines released. When synchronised clk=1 and data=1, go to IDLE.
- Timeout counter: cleared on entry to SEND and on every `fall`; it runs in SEND and ACK. At TIMEOUT_CYCLES: pulse tx_error, set both OEs=0, go to WAIT_IDLE.
- Asynchronous reset at any point, including mid-frame: IDLE, all OEs=0, all outputs 0, counters 0. The line is released immediately.
- `tx_start` in the same cycle as tx_done/tx_error is ignored, because busy is still 1.

## Timing
- Reset values: ps2_clk_out=0, ps2_data_out=0, ps2_clk_oe=0, ps2_data_oe=0, tx_busy=0, tx_done=0, tx_error=0.
- `tx_start` high in cycle N gives tx_busy=1 and clk_oe=1 in N+1.
- data_oe=1 (start bit) in N+1+INHIBIT_CYCLES.
- clk_oe=0 in N+2+INHIBIT_CYCLES.
- A pad falling edge reaches `fall` after 2–3 cycles. The data update follows one cycle later, well within the device's ~30 µs clock-low half-period.
- tx_done or tx_error asserts exactly one cycle, one cycle after the 11th `fall`.
- tx_done and tx_error are never high together.

## Structure
- Shared package `ps2_pkg`:
  - state encoding (IDLE, INHIBIT, START, SEND, ACK, WAIT_IDLE);
  - command constants CMD_RESET=8'hFF, CMD_ENABLE=8'hF4;
  - response constant RSP_ACK=8'hFA, shared with the receiver.
- Sub-module `ps2_line_sync`: 2-flop synchroniser plus falling-edge detect, instantiated twice (clk, data). It has the same async-reset style and resets to 1 so that reset produces no spurious edge.

## Test plan
Bench parameters: INHIBIT_CYCLES=8, TIMEOUT_CYCLES=64. The bench device model generates clocks with a 20-cycle half-period.
- **0xF4**: start → clk driven low for 8 cycles, start bit 0, bits 0,0,1,0,1,1,1,1, P=0, stop released; device ack 0 → one tx_done pulse, no tx_error.
- **0xFF**: start → bits all 1, P=1; device ack 0 → tx_done.
- **NACK**: device leaves data high at the 11th falling edge → one tx_error pulse, tx_done stays 0, return to IDLE once lines are high.
- **Timeout**: device never clocks after the start bit → tx_error 64 cycles after clk_oe drops, both OEs=0.
- **Busy-ignore**: second tx_start with 0x00 during SEND → no effect; the first byte's bits are unchanged.
- **Reset mid-frame**: assert reset after 4 data bits → same cycle, all OEs=0 and busy=0. A new 0xF4 after reset completes normally.
